// File: rtl/excp_irq_controller.sv
// -----------------------------------------------------------------------------
// excp_irq_controller
//   Decides when a synchronous exception or an external interrupt is taken.
//   On entry it strobes the CP0 cause/EPC capture, flushes the pipeline for
//   FLUSH_CYCLES cycles and redirects fetch to EXCP_VECTOR. It also owns the
//   CP0 status register (IE/EXL/IM) and executes ERET, which sends fetch back
//   to the saved EPC.
//
// Ports
//   CLK, RESET          clock (rising edge), asynchronous active-low reset
//   *_STAGE_EXCP        exception flags from decode / execute / memory stages
//   ERET                ERET retiring in MEM this cycle
//   PIPE_STALL          pipeline stalled; interrupts are held off
//   IRQ                 level-sensitive, active-high interrupt lines
//   CSR_WE/SEL/WDATA    CP0 register write port (only reg 12 is decoded here)
//   EPC_IN              current EPC from CP0, used as the ERET target
//   CP0_CAPTURE         one-cycle strobe: CP0 latches cause/EPC on this edge
//   FLUSH               kill all in-flight instructions
//   PC_REDIRECT         fetch takes PC_TARGET this cycle
//   PC_TARGET           redirect address, 0 when not redirecting
//   IRQ_CAUSE           masked pending lines latched at interrupt capture
//   STATUS_OUT          status register: bit0 IE, bit1 EXL, IM at bits 8+
// -----------------------------------------------------------------------------
module excp_irq_controller #(
   parameter int unsigned IRQ_LINES    = 8,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter logic [31:0] EXCP_VECTOR  = 32'h0000DEAD
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 DEC_STAGE_EXCP,
   input  logic                 EXE_STAGE_EXCP,
   input  logic                 MEM_STAGE_EXCP,
   input  logic                 ERET,
   input  logic                 PIPE_STALL,
   input  logic [IRQ_LINES-1:0] IRQ,
   input  logic                 CSR_WE,
   input  logic [4:0]           CSR_SEL,
   input  logic [31:0]          CSR_WDATA,
   input  logic [31:0]          EPC_IN,
   output logic                 CP0_CAPTURE,
   output logic                 FLUSH,
   output logic                 PC_REDIRECT,
   output logic [31:0]          PC_TARGET,
   output logic [IRQ_LINES-1:0] IRQ_CAUSE,
   output logic [31:0]          STATUS_OUT
);

   localparam int unsigned CNT_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [4:0]  SEL_STATUS = 5'd12;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_REDIRECT,
      ST_RETURN
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IRQ_LINES-1:0] irq_q;
   logic [IRQ_LINES-1:0] im_q, im_d;
   logic [IRQ_LINES-1:0] cause_q, cause_d;
   logic                 ie_q, ie_d;
   logic                 exl_q, exl_d;

   logic                 sync_excp;
   logic [IRQ_LINES-1:0] pending;
   logic                 irq_take;
   logic                 capture;
   logic                 csr_status_we;

   // Status bits that have no storage here; folded so they are visibly consumed.
   logic                 unused_wdata;
   assign unused_wdata = ^{CSR_WDATA[31:8+IRQ_LINES], CSR_WDATA[7:2]};

   assign sync_excp     = DEC_STAGE_EXCP | EXE_STAGE_EXCP | MEM_STAGE_EXCP;
   assign pending       = irq_q & im_q;
   assign irq_take      = (|pending) & ie_q & ~exl_q & ~PIPE_STALL;
   assign csr_status_we = CSR_WE && (CSR_SEL == SEL_STATUS);

   // -------------------------------------------------------------------------
   // Next-state logic. CSR writes are applied first so that any FSM update of
   // EXL later in the block overrides the software write on the same edge.
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      ie_d    = ie_q;
      im_d    = im_q;
      exl_d   = exl_q;
      capture = 1'b0;

      if (csr_status_we) begin
         ie_d  = CSR_WDATA[0];
         exl_d = CSR_WDATA[1];
         im_d  = CSR_WDATA[8 +: IRQ_LINES];
      end

      case (state_q)
         ST_IDLE: begin
            if (sync_excp) begin
               // Taken even when already in a handler; CP0 overwrites EPC.
               capture = 1'b1;
               exl_d   = 1'b1;
               cnt_d   = CNT_LOAD;
               state_d = ST_FLUSH;
            end else if (ERET && exl_q) begin
               // EXL is owned by the FSM across the return sequence, so a
               // concurrent software write to EXL is dropped here.
               exl_d   = exl_q;
               state_d = ST_RETURN;
            end else if (irq_take) begin
               capture = 1'b1;
               cause_d = pending;
               exl_d   = 1'b1;
               cnt_d   = CNT_LOAD;
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (cnt_q == '0) state_d = ST_REDIRECT;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         ST_REDIRECT: state_d = ST_IDLE;
         ST_RETURN: begin
            exl_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         irq_q   <= '0;
         cause_q <= '0;
         ie_q    <= 1'b0;
         exl_q   <= 1'b0;
         im_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         irq_q   <= IRQ;
         cause_q <= cause_d;
         ie_q    <= ie_d;
         exl_q   <= exl_d;
         im_q    <= im_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs. Everything except the capture strobe is a decode of the state
   // register; the strobe must be same-cycle so CP0 latches the faulting EPC.
   // -------------------------------------------------------------------------
   assign CP0_CAPTURE = capture;
   assign FLUSH       = (state_q == ST_FLUSH) || (state_q == ST_RETURN);
   assign PC_REDIRECT = (state_q == ST_REDIRECT) || (state_q == ST_RETURN);
   assign IRQ_CAUSE   = cause_q;

   always_comb begin
      PC_TARGET = '0;
      if (state_q == ST_REDIRECT)    PC_TARGET = EXCP_VECTOR;
      else if (state_q == ST_RETURN) PC_TARGET = EPC_IN;
   end

   always_comb begin
      STATUS_OUT                   = '0;
      STATUS_OUT[0]                = ie_q;
      STATUS_OUT[1]                = exl_q;
      STATUS_OUT[8 +: IRQ_LINES]   = im_q;
   end

endmodule

// File: tb/tb_excp_irq_controller.sv
// -----------------------------------------------------------------------------
// tb_excp_irq_controller
//   Cycle-accurate scoreboard bench. Each scenario task drives inputs right
//   after the rising edge, pushes the expected output vector for that cycle,
//   and pops/compares it on the falling edge.
// -----------------------------------------------------------------------------
module tb_excp_irq_controller;

   localparam logic [31:0] VEC = 32'h0000DEAD;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        DEC_STAGE_EXCP = 1'b0, EXE_STAGE_EXCP = 1'b0, MEM_STAGE_EXCP = 1'b0;
   logic        ERET = 1'b0, PIPE_STALL = 1'b0;
   logic [7:0]  IRQ = 8'h0;
   logic        CSR_WE = 1'b0;
   logic [4:0]  CSR_SEL = 5'd12;
   logic [31:0] CSR_WDATA = 32'h0, EPC_IN = 32'h0;
   logic        CP0_CAPTURE, FLUSH, PC_REDIRECT;
   logic [31:0] PC_TARGET, STATUS_OUT;
   logic [7:0]  IRQ_CAUSE;

   excp_irq_controller #(.IRQ_LINES(8), .FLUSH_CYCLES(2), .EXCP_VECTOR(VEC)) dut (
      .CLK(CLK), .RESET(RESET),
      .DEC_STAGE_EXCP(DEC_STAGE_EXCP), .EXE_STAGE_EXCP(EXE_STAGE_EXCP),
      .MEM_STAGE_EXCP(MEM_STAGE_EXCP), .ERET(ERET), .PIPE_STALL(PIPE_STALL),
      .IRQ(IRQ), .CSR_WE(CSR_WE), .CSR_SEL(CSR_SEL), .CSR_WDATA(CSR_WDATA),
      .EPC_IN(EPC_IN), .CP0_CAPTURE(CP0_CAPTURE), .FLUSH(FLUSH),
      .PC_REDIRECT(PC_REDIRECT), .PC_TARGET(PC_TARGET), .IRQ_CAUSE(IRQ_CAUSE),
      .STATUS_OUT(STATUS_OUT)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        cap;
      logic        fl;
      logic        rd;
      logic [31:0] tgt;
      logic [31:0] st;
      logic [7:0]  cause;
   } obs_t;

   obs_t exp_q[$];
   obs_t cur;
   int   total = 0;
   int   passed = 0;

   assign cur = {CP0_CAPTURE, FLUSH, PC_REDIRECT, PC_TARGET, STATUS_OUT, IRQ_CAUSE};

   task automatic push(input int c, input int f, input int r,
                       input logic [31:0] t, input logic [31:0] s, input logic [31:0] q);
      obs_t o;
      o.cap   = (c != 0);
      o.fl    = (f != 0);
      o.rd    = (r != 0);
      o.tgt   = t;
      o.st    = s;
      o.cause = q[7:0];
      exp_q.push_back(o);
   endtask

   task automatic test_reset();
      obs_t e;
      @(posedge CLK); #1;
      push(0, 0, 0, 32'h0, 32'h0, 32'h0);
      e = exp_q.pop_front(); total++;
      if (cur !== e) $display("FAIL reset_held got=%h exp=%h", cur, e); else passed++;
      RESET = 1'b1;
      for (int i = 0; i < 10; i++) begin
         push(0, 0, 0, 32'h0, 32'h0, 32'h0);
         @(negedge CLK);
         e = exp_q.pop_front(); total++;
         if (cur !== e) $display("FAIL reset_idle c%0d got=%h exp=%h", i, cur, e); else passed++;
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_excp();
      obs_t e;
      for (int i = 0; i < 7; i++) begin
         MEM_STAGE_EXCP = (i == 0);
         CSR_WE         = (i == 5);
         CSR_SEL        = 5'd12;
         CSR_WDATA      = 32'h0;
         case (i)
            0:       push(1, 0, 0, 32'h0, 32'h0, 32'h0);
            1, 2:    push(0, 1, 0, 32'h0, 32'h2, 32'h0);
            3:       push(0, 0, 1, VEC,   32'h2, 32'h0);
            4, 5:    push(0, 0, 0, 32'h0, 32'h2, 32'h0);
            default: push(0, 0, 0, 32'h0, 32'h0, 32'h0);
         endcase
         @(negedge CLK);
         e = exp_q.pop_front(); total++;
         if (cur !== e) $display("FAIL excp_entry c%0d got=%h exp=%h", i, cur, e); else passed++;
         @(posedge CLK); #1;
      end
      CSR_WE = 1'b0;
   endtask

   task automatic test_irq();
      obs_t e;
      for (int i = 0; i < 7; i++) begin
         CSR_WE    = (i == 0);
         CSR_WDATA = 32'h0000_0401;
         IRQ       = (i == 1 || i == 2) ? 8'h04 : 8'h00;
         case (i)
            0:       push(0, 0, 0, 32'h0, 32'h0,   32'h0);
            1:       push(0, 0, 0, 32'h0, 32'h401, 32'h0);
            2:       push(1, 0, 0, 32'h0, 32'h401, 32'h0);
            3, 4:    push(0, 1, 0, 32'h0, 32'h403, 32'h04);
            5:       push(0, 0, 1, VEC,   32'h403, 32'h04);
            default: push(0, 0, 0, 32'h0, 32'h403, 32'h04);
         endcase
         @(negedge CLK);
         e = exp_q.pop_front(); total++;
         if (cur !== e) $display("FAIL irq_take c%0d got=%h exp=%h", i, cur, e); else passed++;
         @(posedge CLK); #1;
      end
      CSR_WE = 1'b0;
   endtask

   task automatic test_eret();
      obs_t e;
      for (int i = 0; i < 5; i++) begin
         IRQ    = (i < 2) ? 8'h04 : 8'h00;
         ERET   = (i == 2);
         EPC_IN = 32'h0000_1234;
         case (i)
            0, 1, 2: push(0, 0, 0, 32'h0,        32'h403, 32'h04);
            3:       push(0, 1, 1, 32'h0000_1234, 32'h403, 32'h04);
            default: push(0, 0, 0, 32'h0,        32'h401, 32'h04);
         endcase
         @(negedge CLK);
         e = exp_q.pop_front(); total++;
         if (cur !== e) $display("FAIL eret_return c%0d got=%h exp=%h", i, cur, e); else passed++;
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_stall();
      obs_t e;
      for (int i = 0; i < 10; i++) begin
         CSR_WE     = (i == 0 || i == 8);
         CSR_WDATA  = 32'h0000_0C01;
         PIPE_STALL = (i >= 1 && i <= 3);
         IRQ        = (i >= 1 && i <= 4) ? 8'h1C : 8'h00;
         case (i)
            0:          push(0, 0, 0, 32'h0, 32'h401, 32'h04);
            1, 2, 3:    push(0, 0, 0, 32'h0, 32'hC01, 32'h04);
            4:          push(1, 0, 0, 32'h0, 32'hC01, 32'h04);
            5, 6:       push(0, 1, 0, 32'h0, 32'hC03, 32'h0C);
            7:          push(0, 0, 1, VEC,   32'hC03, 32'h0C);
            8:          push(0, 0, 0, 32'h0, 32'hC03, 32'h0C);
            default:    push(0, 0, 0, 32'h0, 32'hC01, 32'h0C);
         endcase
         @(negedge CLK);
         e = exp_q.pop_front(); total++;
         if (cur !== e) $display("FAIL irq_stall c%0d got=%h exp=%h", i, cur, e); else passed++;
         @(posedge CLK); #1;
      end
      CSR_WE = 1'b0;
   endtask

   task automatic test_priority();
      obs_t e;
      for (int i = 0; i < 11; i++) begin
         DEC_STAGE_EXCP = (i == 1);
         EXE_STAGE_EXCP = (i == 2 || i == 3);
         ERET           = (i == 1 || i == 7);
         EPC_IN         = 32'h0000_1234;
         CSR_WE         = (i == 0 || i == 1 || i == 6 || i == 9);
         CSR_SEL        = (i == 9) ? 5'd13 : 5'd12;
         case (i)
            0:       CSR_WDATA = 32'h0000_0003;
            9:       CSR_WDATA = 32'hFFFF_FFFF;
            default: CSR_WDATA = 32'h0000_0001;
         endcase
         case (i)
            0:       push(0, 0, 0, 32'h0, 32'hC01, 32'h0C);
            1:       push(1, 0, 0, 32'h0, 32'h003, 32'h0C);
            2, 3:    push(0, 1, 0, 32'h0, 32'h003, 32'h0C);
            4:       push(0, 0, 1, VEC,   32'h003, 32'h0C);
            5, 6:    push(0, 0, 0, 32'h0, 32'h003, 32'h0C);
            default: push(0, 0, 0, 32'h0, 32'h001, 32'h0C);
         endcase
         @(negedge CLK);
         e = exp_q.pop_front(); total++;
         if (cur !== e) $display("FAIL excp_priority c%0d got=%h exp=%h", i, cur, e); else passed++;
         @(posedge CLK); #1;
      end
      CSR_WE = 1'b0;
      CSR_SEL = 5'd12;
   endtask

   task automatic test_reset_mid();
      obs_t e;
      for (int i = 0; i < 2; i++) begin
         EXE_STAGE_EXCP = (i == 0);
         if (i == 0) push(1, 0, 0, 32'h0, 32'h001, 32'h0C);
         else        push(0, 1, 0, 32'h0, 32'h003, 32'h0C);
         @(negedge CLK);
         e = exp_q.pop_front(); total++;
         if (cur !== e) $display("FAIL reset_mid_entry c%0d got=%h exp=%h", i, cur, e); else passed++;
         @(posedge CLK); #1;
      end
      // Second flush cycle: confirm, then pull reset mid-cycle.
      push(0, 1, 0, 32'h0, 32'h003, 32'h0C);
      e = exp_q.pop_front(); total++;
      if (cur !== e) $display("FAIL reset_mid_flush2 got=%h exp=%h", cur, e); else passed++;
      RESET = 1'b0;
      #1;
      push(0, 0, 0, 32'h0, 32'h0, 32'h0);
      e = exp_q.pop_front(); total++;
      if (cur !== e) $display("FAIL reset_mid_async got=%h exp=%h", cur, e); else passed++;
      @(posedge CLK); #1;
      RESET = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push(0, 0, 0, 32'h0, 32'h0, 32'h0);
         @(negedge CLK);
         e = exp_q.pop_front(); total++;
         if (cur !== e) $display("FAIL reset_mid_after c%0d got=%h exp=%h", i, cur, e); else passed++;
         @(posedge CLK); #1;
      end
   endtask

   initial begin
      test_reset();
      test_excp();
      test_irq();
      test_eret();
      test_stall();
      test_priority();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/excp_irq_controller.md
Name: excp_irq_controller

Overview:
Sequencing controller for the CP0 exception datapath. It decides when an exception or external interrupt is taken, and strobes the CP0 cause/EPC capture. It then flushes the pipeline for a fixed number of cycles and redirects fetch to the exception vector. It also owns the status register (IE/EXL/IM) and executes ERET, returning fetch to the saved EPC.

Parameters:
IRQ_LINES, 8, number of external level-sensitive interrupt lines (1..16)
FLUSH_CYCLES, 2, cycles FLUSH is held after a capture (>=1)
EXCP_VECTOR, 32'h0000DEAD, fetch target on exception/interrupt entry

Ports:
CLK  in  1  system clock, all state on rising edge
RESET  in  1  asynchronous, active-low reset
DEC_STAGE_EXCP  in  1  exception flagged by the decode-stage instruction
EXE_STAGE_EXCP  in  1  exception flagged by the execute-stage instruction
MEM_STAGE_EXCP  in  1  exception flagged by the memory-stage instruction
ERET  in  1  ERET retiring in the MEM stage this cycle
PIPE_STALL  in  1  pipeline stalled; interrupts must not be taken
IRQ  in  IRQ_LINES  external interrupt requests, level, active-high
CSR_WE  in  1  CP0 register write strobe
CSR_SEL  in  5  CP0 register number for the write
CSR_WDATA  in  32  CP0 write data
EPC_IN  in  32  current EPC value from CP0 (return target)
CP0_CAPTURE  out  1  one-cycle strobe: CP0 latches cause/EPC this edge
FLUSH  out  1  kill all in-flight instructions
PC_REDIRECT  out  1  fetch takes PC_TARGET this cycle
PC_TARGET  out  32  redirect address
IRQ_CAUSE  out  IRQ_LINES  masked pending lines latched at interrupt capture
STATUS_OUT  out  32  status register (CP0 reg 12)

Behaviour:
- Reset (RESET=0, async): state IDLE.
  - FLUSH, PC_REDIRECT and CP0_CAPTURE are 0.
  - PC_TARGET = 0.
  - IRQ_CAUSE = 0.
  - STATUS_OUT = 0: IE=0, EXL=0, IM=0.
- STATUS_OUT layout:
  - bit0 = IE.
  - bit1 = EXL.
  - bits[8+IRQ_LINES-1:8] = IM.
  - All other bits read 0.
- IRQ is registered once (irq_q).
- pending = irq_q & IM.
- irq_take = |pending & IE & ~EXL & ~PIPE_STALL.
- FSM states: IDLE, FLUSH, REDIRECT, RETURN.
- IDLE priority, highest first:
  1. any *_STAGE_EXCP → CP0_CAPTURE=1 (combinational, same cycle); next state FLUSH; EXL←1. Taken even if EXL=1 (nested; EPC is overwritten). IRQ_CAUSE is not updated.
  2. ERET with EXL=1 → next state RETURN. ERET with EXL=0 is ignored; state stays IDLE.
  3. irq_take → CP0_CAPTURE=1; IRQ_CAUSE←pending; EXL←1; next state FLUSH.
- FLUSH state:
  - FLUSH=1 for exactly FLUSH_CYCLES consecutive cycles, counted by an internal counter loaded on entry.
  - Then REDIRECT.
- REDIRECT state: PC_REDIRECT=1 and PC_TARGET=EXCP_VECTOR for 1 cycle, then IDLE.
- RETURN state: for 1 cycle FLUSH=1, PC_REDIRECT=1, PC_TARGET=EPC_IN, EXL←0; then IDLE.
- PC_TARGET = 0 whenever PC_REDIRECT=0.
- Exception entry timing: detect at cycle T; FLUSH=1 at T+1..T+FLUSH_CYCLES; PC_REDIRECT at T+FLUSH_CYCLES+1; IDLE at T+FLUSH_CYCLES+2.
- In FLUSH, REDIRECT and RETURN, *_STAGE_EXCP and ERET are ignored (they come from killed instructions). IRQ keeps being sampled into irq_q.
- CSR writes:
  - CSR_WE with CSR_SEL=12 writes IE and IM from CSR_WDATA in any state.
  - EXL is writable only when no capture or RETURN transition happens that edge. The FSM's EXL update wins over the CSR write.
  - Writes to other CSR_SEL values have no effect.
- A deasserting IRQ line after capture does not alter IRQ_CAUSE. IRQ_CAUSE holds until the next interrupt capture.
- PIPE_STALL never delays synchronous exceptions or ERET.

Test Plan:
- Reset then idle: all outputs 0 for 10 cycles; STATUS_OUT=0.
- MEM_STAGE_EXCP=1 for one cycle at T → CP0_CAPTURE=1 at T; FLUSH=1 at T+1 and T+2; PC_REDIRECT=1 with PC_TARGET=32'h0000DEAD at T+3; STATUS_OUT bit1=1 from T+1.
- Write CSR 12 = 32'h0000_0401 (IE=1, IM bit2); raise IRQ[2] → capture two cycles after the IRQ edge; IRQ_CAUSE=8'h04. Repeat with PIPE_STALL=1 → no capture until the stall drops.
- Inside the handler (EXL=1), raise IRQ[2] → no capture. Then ERET with EPC_IN=32'h0000_1234 → next cycle FLUSH=1, PC_REDIRECT=1, PC_TARGET=32'h0000_1234; EXL=0 afterwards.
- DEC_STAGE_EXCP and ERET asserted in the same IDLE cycle → exception path is taken, ERET is dropped. EXE_STAGE_EXCP during FLUSH → ignored, no second capture.
- Assert RESET low during the second FLUSH cycle → outputs 0 immediately, state IDLE, EXL=0; no redirect after release.
